// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: shared backend defines for the dispatch controller
// Holds the fetch width, the default post-redirect blackout length and the
// dispatch controller state type.
package dispatch_ctrl_pkg;
  localparam int FETCH_WIDTH = 4;
  localparam int HOLD_CYCLES_DEF = 2;
  typedef enum logic [1:0] {RUN, STALL, RECOVER, SERIAL} dis_ctrl_state_e;
endpackage

// File: rtl/dis_ctrl_counter.sv
// dis_ctrl_counter: event counter that either saturates at all-ones or wraps
// Ports: clk, rst (sync, active-high), inc (count this cycle), count (value).
// SAT=1 saturates, SAT=0 wraps.
module dis_ctrl_counter #(
  parameter int WIDTH = 32,
  parameter bit SAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = (inc && !(SAT && &count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: dispatch stall / redirect-recovery / serialization controller
// Ports: clk, rst (sync, active-high); rename_en, serial_req per fetch slot;
// q_full per dispatch queue; redirect, serial_done pulses; outputs dis_full,
// recovering, stall_cycles (saturating), redirect_cnt (wrapping, 16 bits).
// Macro DISPATCH_CTRL_SERIAL_EN compiles in the SERIAL state.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int NQ = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FETCH_WIDTH-1:0] rename_en,
  input  logic [NQ-1:0]          q_full,
  input  logic                   redirect,
  input  logic [FETCH_WIDTH-1:0] serial_req,
  input  logic                   serial_done,
  output logic                   dis_full,
  output logic                   recovering,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic [15:0]            redirect_cnt
);
  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
  dis_ctrl_state_e state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic stall_req;
`ifndef DISPATCH_CTRL_SERIAL_EN
  logic unused_serial;
  assign unused_serial = ^{serial_req, serial_done};
`endif
  assign stall_req = |q_full & |rename_en;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    dis_full = 1'b0;
    recovering = 1'b0;
    if (!rst) begin
      dis_full = (state_q == RUN) ? stall_req : 1'b1;
      recovering = state_q == RECOVER;
    end
    if (redirect) begin
      state_d = RECOVER;
      hold_d = HOLD_M1;
    end else if (state_q == RECOVER) begin
      state_d = (hold_q == 4'd0) ? RUN : RECOVER;
      hold_d = (hold_q == 4'd0) ? 4'd0 : hold_q - 4'd1;
    end
`ifdef DISPATCH_CTRL_SERIAL_EN
    else if (state_q == SERIAL) state_d = serial_done ? RUN : SERIAL;
    else if (state_q == STALL) state_d = |q_full ? STALL : RUN;
    else state_d = stall_req ? STALL : (|(rename_en & serial_req) ? SERIAL : RUN);
`else
    else if (state_q == STALL) state_d = |q_full ? STALL : RUN;
    else state_d = stall_req ? STALL : RUN;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hold_q <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
    end
  end
  dis_ctrl_counter #(.WIDTH(CNT_WIDTH), .SAT(1'b1)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(dis_full), .count(stall_cycles)
  );
  dis_ctrl_counter #(.WIDTH(16), .SAT(1'b0)) u_redirect_cnt (
    .clk(clk), .rst(rst), .inc(redirect), .count(redirect_cnt)
  );
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed and random checks of dispatch_ctrl against a behavioural model
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;
  localparam int NQ = 4;
  localparam int HOLD = 2;
  localparam int CW = 5;
`ifdef DISPATCH_CTRL_SERIAL_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, redirect = 1'b0, serial_done = 1'b0;
  logic [FETCH_WIDTH-1:0] rename_en = '0, serial_req = '0;
  logic [NQ-1:0] q_full = '0;
  logic dis_full, recovering;
  logic [CW-1:0] stall_cycles;
  logic [15:0] redirect_cnt;
  int checks = 0, fails = 0;
  int m_black = 0, m_scnt = 0;
  bit m_stall = 1'b0, m_ser = 1'b0;
  logic [15:0] m_rcnt = '0;

  dispatch_ctrl #(.NQ(NQ), .HOLD_CYCLES(HOLD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rename_en(rename_en), .q_full(q_full),
    .redirect(redirect), .serial_req(serial_req), .serial_done(serial_done),
    .dis_full(dis_full), .recovering(recovering),
    .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_df();
    return !rst && (m_black > 0 || m_stall || m_ser || (|q_full && |rename_en));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_black = 0; m_stall = 1'b0; m_ser = 1'b0; m_scnt = 0; m_rcnt = '0;
    end else begin
      if (exp_df() && m_scnt < 2**CW - 1) m_scnt++;
      if (redirect) begin
        m_rcnt++; m_black = HOLD; m_stall = 1'b0; m_ser = 1'b0;
      end else if (m_black > 0) m_black--;
      else if (m_ser) m_ser = !serial_done;
      else if (m_stall) m_stall = |q_full;
      else begin
        m_stall = |q_full && |rename_en;
        m_ser = SER && !m_stall && |(rename_en & serial_req);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("dis_full", 32'(dis_full), 32'(exp_df()));
    chk("recovering", 32'(recovering), 32'(!rst && m_black > 0));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_scnt));
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_rcnt));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    repeat (2) cycle();
    chk("reset_df", 32'(dis_full), 32'd0);
    rst = 1'b0;
    cycle();
    rename_en = 4'b0011; q_full = 4'b0100;
    repeat (3) cycle();
    q_full = '0;
    repeat (2) cycle();
    chk("stall_run_df", 32'(dis_full), 32'd0);
    chk("stall_count4", 32'(stall_cycles), 32'd4);
    rename_en = '0;
    redirect = 1'b1; cycle(); redirect = 1'b0;
    chk("rec_cyc1", 32'(recovering), 32'd1);
    cycle();
    chk("rec_cyc2", 32'(recovering), 32'd1);
    cycle();
    chk("rec_done", 32'(recovering), 32'd0);
    chk("rec_done_df", 32'(dis_full), 32'd0);
    chk("redir_cnt1", 32'(redirect_cnt), 32'd1);
    redirect = 1'b1; repeat (2) cycle(); redirect = 1'b0;
    chk("rerec_cyc1", 32'(recovering), 32'd1);
    cycle();
    chk("rerec_cyc2", 32'(recovering), 32'd1);
    cycle();
    chk("rerec_done", 32'(recovering), 32'd0);
    chk("redir_cnt3", 32'(redirect_cnt), 32'd3);
    rename_en = 4'b0001; serial_req = 4'b0001; cycle();
    rename_en = '0; serial_req = '0;
    chk("serial_df", 32'(dis_full), 32'(SER));
    repeat (4) cycle();
    serial_done = 1'b1; cycle(); serial_done = 1'b0;
    chk("serial_done_df", 32'(dis_full), 32'd0);
    redirect = 1'b1; cycle(); redirect = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_rec_df", 32'(dis_full), 32'd0);
    chk("rst_rec_rec", 32'(recovering), 32'd0);
    chk("rst_rec_scnt", 32'(stall_cycles), 32'd0);
    chk("rst_rec_rcnt", 32'(redirect_cnt), 32'd0);
    cycle();
    rename_en = 4'hf; q_full = 4'h1;
    repeat (35) cycle();
    chk("sat_count", 32'(stall_cycles), 32'd31);
    rename_en = '0; q_full = '0;
    repeat (2) cycle();
    repeat (3000) begin
      rst = $urandom_range(99) == 0;
      redirect = $urandom_range(15) == 0;
      rename_en = 4'($urandom);
      q_full = ($urandom_range(2) == 0) ? 4'($urandom) : '0;
      serial_req = ($urandom_range(3) == 0) ? 4'($urandom) : '0;
      serial_done = $urandom_range(3) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
